ex_unit_mc: RTL and testbench

Parametrised, handshaked execute unit for the 16-bit core: successor to the single-cycle execute stage, generalised to DW-bit datapath and AW-bit register addressing. Accepts one decoded operation per cycle (valid/ready), computes ALU/shift results in one cycle and multiplies over DW cycles, holds the result in an output register until the write-back stage takes it, and owns the 4-bit PSR (N,Z,C,V). Sits between decode/operand fetch and write-back.

---
 rtl/ex_unit_mc.sv | 241 ++++++++++++++++++++++++
 tb/tb_ex_unit_mc.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_unit_mc.sv
// Handshaked execute unit: single-cycle ALU/shifts, DW-cycle shift-add MUL, owner of PSR {N,Z,C,V}.
// Optional multiplier is built only when EX_MUL_EN is defined; otherwise op 12 returns an illegal-op result.
module ex_unit_mc #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [3:0]    op_i,
  input  logic          set_flags_i,
  input  logic          wr_in_i,
  input  logic [AW-1:0] dest_in_i,
  input  logic [DW-1:0] src_a_i,
  input  logic [DW-1:0] src_b_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] data_out_o,
  output logic [AW-1:0] dest_out_o,
  output logic          wr_o,
  output logic          illegal_op_o,
  output logic [3:0]    psr_flags_o,
  output logic          busy_o
);
  localparam int CW = $clog2(DW);
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] SH_DW  = SW'(DW);
  localparam logic [SW-1:0] SH_ONE = SW'(1);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4,  OP_MOV = 4'd5,  OP_MVN = 4'd6,  OP_LSL = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8,  OP_ASR = 4'd9,  OP_ROR = 4'd10, OP_CMP = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_ADC = 4'd13, OP_SBC = 4'd14, OP_TST = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_FULL, S_MUL} state_t;
  state_t state_q, state_d;

  logic          accept, op_is_mul, mul_done;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] dest_q, dest_d;
  logic          wr_q, wr_d, ill_q, ill_d;
  logic [3:0]    psr_q, psr_d;

  logic [DW:0]   sum;
  logic [DW-1:0] res;
  logic          c_new, v_new, alu_wr, alu_ill, alu_upd;
  logic [SW-1:0] sh, sh_m1, rot_amt, rot_left;
  logic [3:0]    alu_psr;

  assign sh       = src_b_i[SW-1:0];
  assign sh_m1    = sh - SH_ONE;
  assign rot_amt  = {1'b0, sh[SW-2:0]};
  assign rot_left = SH_DW - rot_amt;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = op_is_mul ? S_MUL : S_FULL;
      S_FULL: begin
        if (accept)           state_d = op_is_mul ? S_MUL : S_FULL;
        else if (out_ready_i) state_d = S_IDLE;
      end
      S_MUL:  if (mul_done) state_d = S_FULL;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_comb begin
    in_ready_o  = !flush_i && ((state_q == S_IDLE) || ((state_q == S_FULL) && out_ready_i));
    out_valid_o = (state_q == S_FULL);
    busy_o      = (state_q == S_MUL);
  end

  assign accept = in_valid_i & in_ready_o;

  // Single-cycle datapath; C and V default to their held values so ops that leave them alone just fall through.
  always_comb begin
    sum     = '0;
    res     = '0;
    c_new   = psr_q[1];
    v_new   = psr_q[0];
    alu_wr  = wr_in_i;
    alu_ill = 1'b0;
    alu_upd = 1'b1;
    case (op_i)
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, src_a_i} + {1'b0, src_b_i} + {{DW{1'b0}}, (op_i == OP_ADC) & psr_q[1]};
        res   = sum[DW-1:0];
        c_new = sum[DW];
        v_new = (src_a_i[DW-1] == src_b_i[DW-1]) && (res[DW-1] != src_a_i[DW-1]);
      end
      OP_SUB, OP_CMP, OP_SBC: begin
        sum    = {1'b0, src_a_i} - {1'b0, src_b_i} - {{DW{1'b0}}, (op_i == OP_SBC) & ~psr_q[1]};
        res    = sum[DW-1:0];
        c_new  = ~sum[DW];
        v_new  = (src_a_i[DW-1] != src_b_i[DW-1]) && (res[DW-1] != src_a_i[DW-1]);
        alu_wr = wr_in_i & (op_i != OP_CMP);
      end
      OP_AND: res = src_a_i & src_b_i;
      OP_ORR: res = src_a_i | src_b_i;
      OP_EOR: res = src_a_i ^ src_b_i;
      OP_MOV: res = src_b_i;
      OP_MVN: res = ~src_b_i;
      OP_TST: begin
        res    = src_a_i & src_b_i;
        alu_wr = 1'b0;
      end
      OP_LSL: begin
        res = src_a_i << sh;
        if (sh != '0) c_new = (sh > SH_DW) ? 1'b0 : src_a_i[CW'(SH_DW - sh)];
      end
      OP_LSR: begin
        res = src_a_i >> sh;
        if (sh != '0) c_new = (sh > SH_DW) ? 1'b0 : src_a_i[CW'(sh_m1)];
      end
      OP_ASR: begin
        res = $signed(src_a_i) >>> sh;
        if (sh != '0) c_new = (sh >= SH_DW) ? src_a_i[DW-1] : src_a_i[CW'(sh_m1)];
      end
      OP_ROR: begin
        res = (src_a_i >> rot_amt) | (src_a_i << rot_left);
        if (sh != '0) c_new = res[DW-1];
      end
      OP_MUL: begin
        alu_wr  = 1'b0;
        alu_ill = 1'b1;
        alu_upd = 1'b0;
      end
      default: res = '0;
    endcase
    alu_psr = {res[DW-1], (res == '0), c_new, v_new};
  end

`ifdef EX_MUL_EN
  logic [DW-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, mul_sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mul_sf_q, mul_sf_d;

  assign op_is_mul = (op_i == OP_MUL);
  assign mul_done  = (state_q == S_MUL) && (cnt_q == CW'(DW - 1));
  assign mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Radix-2 shift-add: multiplicand walks left, multiplier right, one partial product per cycle.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_sf_d = mul_sf_q;
    if (accept && op_is_mul) begin
      mcand_d  = src_a_i;
      mplier_d = src_b_i;
      acc_d    = '0;
      cnt_d    = '0;
      mul_sf_d = set_flags_i;
    end else if (state_q == S_MUL) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = mul_sum;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_sf_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mul_sf_q <= mul_sf_d;
    end
  end
`else
  assign op_is_mul = 1'b0;
  assign mul_done  = 1'b0;
`endif

  always_comb begin
    data_d = data_q;
    dest_d = dest_q;
    wr_d   = wr_q;
    ill_d  = ill_q;
    psr_d  = psr_q;
    if (accept) begin
      dest_d = dest_in_i;
      if (op_is_mul) begin
        wr_d  = wr_in_i;
        ill_d = 1'b0;
      end else begin
        data_d = res;
        wr_d   = alu_wr;
        ill_d  = alu_ill;
        if (set_flags_i && alu_upd) psr_d = alu_psr;
      end
    end
`ifdef EX_MUL_EN
    // A flush on the final MUL cycle still aborts: no result, no PSR write.
    if (mul_done && !flush_i) begin
      data_d = mul_sum;
      if (mul_sf_q) psr_d = {mul_sum[DW-1], (mul_sum == '0), psr_q[1:0]};
    end
`endif
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      data_q <= '0;
      dest_q <= '0;
      wr_q   <= 1'b0;
      ill_q  <= 1'b0;
      psr_q  <= 4'b0000;
    end else begin
      data_q <= data_d;
      dest_q <= dest_d;
      wr_q   <= wr_d;
      ill_q  <= ill_d;
      psr_q  <= psr_d;
    end
  end

  assign data_out_o   = data_q;
  assign dest_out_o   = dest_q;
  assign wr_o         = wr_q;
  assign illegal_op_o = ill_q;
  assign psr_flags_o  = psr_q;

endmodule

// File: tb/tb_ex_unit_mc.sv
// Randomised scoreboard bench for ex_unit_mc (DW=16, AW=3) with directed boundary cases.
module tb_ex_unit_mc;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, set_flags, wr_in, out_ready;
  logic [3:0]  op;
  logic [2:0]  dest;
  logic [15:0] a, b;
  logic        in_ready, out_valid, wr_out, illegal, busy;
  logic [15:0] data_out;
  logic [2:0]  dest_out;
  logic [3:0]  psr;

  ex_unit_mc #(.DW(16), .AW(3)) dut (
    .clk_i(clk), .resetn_i(resetn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .set_flags_i(set_flags), .wr_in_i(wr_in), .dest_in_i(dest), .src_a_i(a), .src_b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .data_out_o(data_out), .dest_out_o(dest_out),
    .wr_o(wr_out), .illegal_op_o(illegal), .psr_flags_o(psr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dest;
    logic        wr, ill, is_mul;
    logic [3:0]  psr, psr_before;
    int          acc_edge;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mpsr = 4'b0000;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic bit ovf(input longint x);
    return (x < -32768) || (x > 32767);
  endfunction

  // Reference behaviour from the ISA rules using plain integer arithmetic.
  function automatic void model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                input logic [3:0] pin, input logic wr,
                                output logic [15:0] r, output logic w, output logic ill,
                                output logic [3:0] pout);
    longint ux, uy, sx, sy, s, cin;
    int n, m;
    logic c, v, upd;
    ux = longint'(x); uy = longint'(y);
    sx = longint'($signed(x)); sy = longint'($signed(y));
    n = int'(y[4:0]);
    c = pin[1]; v = pin[0]; upd = 1'b1; ill = 1'b0; w = wr; r = '0; s = 0;
    case (o)
      4'd0, 4'd13: begin
        cin = (o == 4'd13 && pin[1]) ? 1 : 0;
        s = ux + uy + cin; r = s[15:0]; c = s[16]; v = ovf(sx + sy + cin);
      end
      4'd1, 4'd11, 4'd14: begin
        cin = (o == 4'd14 && !pin[1]) ? 1 : 0;
        s = ux - uy - cin; r = s[15:0]; c = (s >= 0); v = ovf(sx - sy - cin);
        if (o == 4'd11) w = 1'b0;
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = y;
      4'd6: r = ~y;
      4'd15: begin r = x & y; w = 1'b0; end
      4'd7: begin
        r = x;
        if (n != 0) begin s = ux << n; r = s[15:0]; c = (n <= 16) ? s[16] : 1'b0; end
      end
      4'd8: begin
        r = x;
        if (n != 0) begin r = 16'(ux >> n); c = (n <= 16) ? (((ux >> (n - 1)) & 1) != 0) : 1'b0; end
      end
      4'd9: begin
        r = x;
        if (n >= 16) begin r = (sx < 0) ? 16'hFFFF : 16'h0000; c = (sx < 0); end
        else if (n != 0) begin r = 16'(sx >>> n); c = ((ux >> (n - 1)) & 1) != 0; end
      end
      4'd10: begin
        r = x;
        if (n != 0) begin m = n % 16; s = (ux >> m) | (ux << (16 - m)); r = s[15:0]; c = r[15]; end
      end
      default: begin
`ifdef EX_MUL_EN
        s = ux * uy; r = s[15:0];
`else
        r = '0; w = 1'b0; ill = 1'b1; upd = 1'b0;
`endif
      end
    endcase
    pout = upd ? {r[15], (r == 16'h0), c, v} : pin;
  endfunction

  // Decides acceptance just before the edge and records the expected result.
  task automatic sample_accept(output bit acc);
    exp_t e;
    acc = 1'b0;
    if (flush) begin
      chk("in_ready_during_flush", in_ready, 0);
      if (sb.size() > 0 && sb[0].is_mul && (cyc + 1) <= sb[0].acc_edge + DW) mpsr = sb[0].psr_before;
      sb.delete();
    end else if (in_valid && in_ready) begin
      acc = 1'b1;
      e.psr_before = mpsr;
      model(op, a, b, mpsr, wr_in, e.data, e.wr, e.ill, e.psr);
      if (!set_flags) e.psr = mpsr;
      mpsr = e.psr;
      e.dest = dest;
      e.acc_edge = cyc + 1;
`ifdef EX_MUL_EN
      e.is_mul = (op == 4'd12);
`else
      e.is_mul = 1'b0;
`endif
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic sf, input logic w, input logic [2:0] d);
    bit acc;
    int n;
    n = 0; acc = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y; set_flags = sf; wr_in = w; dest = d;
    while (!acc && n < 100) begin
      #4;
      sample_accept(acc);
      @(negedge clk);
      n++;
    end
    if (!acc) chk("send_accept_timeout", 32'(acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic send_hold(input string name, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] exp_d, input logic [3:0] exp_p, input logic exp_ill);
    out_ready = 1'b0;
    send(o, x, y, 1'b1, 1'b1, 3'd3);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, data_out, exp_d);
    chk({name, "_psr"}, psr, exp_p);
    chk({name, "_illegal"}, illegal, exp_ill);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Monitor: every result taken by write-back is compared against the scoreboard head.
  initial begin
    exp_t e;
    int wd;
    wd = 0;
    forever begin
      @(negedge clk);
      #3;
      if (!resetn) continue;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.data);
          chk("dest_out", dest_out, e.dest);
          chk("wr_out", wr_out, e.wr);
          chk("illegal_op", illegal, e.ill);
          chk("psr_flags", psr, e.psr);
        end
        wd = 0;
      end else if (out_ready && sb.size() > 0) begin
        wd++;
        if (wd > DW + 4) begin
          checks++; errors++;
          $display("FAIL result_timeout: no result within %0d ready cycles", wd);
          void'(sb.pop_front());
          wd = 0;
        end
      end
    end
  end

  initial begin
    bit acc;
    int n, bc, irb;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    set_flags = 1'b0; wr_in = 1'b0; dest = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0); chk("rst_data", data_out, 0); chk("rst_dest", dest_out, 0);
    chk("rst_wr", wr_out, 0); chk("rst_illegal", illegal, 0); chk("rst_psr", psr, 0);
    chk("rst_busy", busy, 0); chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    send_hold("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0);
    send_hold("sub_eq", 4'd1, 16'h0005, 16'h0005, 16'h0000, 4'b0110, 1'b0);
    send_hold("adc_c", 4'd13, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 1'b0);
    send_hold("asr20", 4'd9, 16'h8000, 16'd20, 16'hFFFF, 4'b1010, 1'b0);
    send_hold("lsl16", 4'd7, 16'h0001, 16'd16, 16'h0000, 4'b0110, 1'b0);

`ifdef EX_MUL_EN
    out_ready = 1'b0;
    send(4'd12, 16'h00FF, 16'h0101, 1'b1, 1'b1, 3'd6);
    bc = 0; irb = 0; n = 0;
    while (!out_valid && n < DW + 5) begin
      if (busy) bc++;
      if (in_ready) irb++;
      @(negedge clk);
      n++;
    end
    chk("mul_busy_cycles", bc, DW); chk("mul_in_ready_high", irb, 0);
    chk("mul_valid", out_valid, 1); chk("mul_busy_end", busy, 0);
    chk("mul_data", data_out, 16'hFFFF); chk("mul_psr", psr, 4'b1010);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

    out_ready = 1'b1;
    send(4'd12, 16'h8000, 16'h0001, 1'b1, 1'b1, 3'd1);
    repeat (6) @(negedge clk);
    flush = 1'b1; out_ready = 1'b0; in_valid = 1'b1; op = 4'd0; a = 16'h1; b = 16'h1;
    #4 sample_accept(acc);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("mflush_valid", out_valid, 0); chk("mflush_in_ready", in_ready, 1);
    chk("mflush_busy", busy, 0); chk("mflush_psr", psr, mpsr);
    n = 0;
    repeat (DW + 2) begin @(negedge clk); #1; if (out_valid) n++; end
    chk("mflush_no_result", n, 0);
    @(negedge clk);

    send(4'd12, 16'h1234, 16'h5678, 1'b1, 1'b1, 3'd2);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mrst_busy", busy, 0); chk("mrst_valid", out_valid, 0); chk("mrst_psr", psr, 0);
    chk("mrst_data", data_out, 0); chk("mrst_in_ready", in_ready, 1);
    sb.delete(); mpsr = 4'b0000;
    @(negedge clk); resetn = 1'b1; @(negedge clk);
`else
    send_hold("mul_illegal", 4'd12, 16'h00FF, 16'h0101, 16'h0000, 4'b0110, 1'b1);
`endif

    // Stalled write-back: held result stays put, new op waits, then both go through.
    out_ready = 1'b0;
    send(4'd0, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 3'd4);
    in_valid = 1'b1; op = 4'd4; a = 16'($urandom); b = 16'($urandom); set_flags = 1'b1; wr_in = 1'b1; dest = 3'd5;
    for (int i = 0; i < 5; i++) begin
      #4;
      sample_accept(acc);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_data", data_out, sb[0].data);
      @(negedge clk);
    end
    out_ready = 1'b1; n = 0; acc = 1'b0;
    while (!acc && n < 20) begin #4; sample_accept(acc); @(negedge clk); n++; end
    chk("stall_release_accept", 32'(acc), 1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    out_ready = 1'b0;
    send(4'd3, 16'h00F0, 16'h0F00, 1'b1, 1'b1, 3'd7);
    flush = 1'b1; in_valid = 1'b1; op = 4'd1;
    #4 sample_accept(acc);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("hflush_valid", out_valid, 0); chk("hflush_in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      flush     = ($urandom % 100) < 3;
      out_ready = flush ? 1'b0 : (($urandom % 10) < 7);
      in_valid  = ($urandom % 10) < 7;
      op        = 4'($urandom);
      a         = (($urandom % 4) == 0) ? 16'h7FFF << ($urandom % 2) : 16'($urandom);
      b         = (($urandom % 4) == 0) ? 16'h8000 >> ($urandom % 16) : 16'($urandom);
      set_flags = ($urandom % 4) != 0;
      wr_in     = 1'($urandom);
      dest      = 3'($urandom);
      #4;
      sample_accept(acc);
      @(negedge clk);
    end

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
